pwm_ramp_controller: RTL and testbench
======================================

Name: pwm_ramp_controller

Overview:
- Sequences the duty-cycle setting of the existing 8-bit PWM counter/compare datapath.
- Accepts target-duty commands from a host over a valid/ready handshake.
- Ramps the applied duty toward the target by STEP counts, once per PWM period boundary (soft start / soft stop).
- Gates the PWM core enable, so the duty never changes mid-period and the output never jumps.

Parameters:
- DW, 8: width of the duty and compare values; matches the PWM counter width.
- MAX_DUTY, 100: highest legal duty count, equal to the PWM period length; requires MAX_DUTY <= 2^DW-1.
- STEP, 5: duty increment or decrement per period boundary; requires 1 <= STEP <= MAX_DUTY.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; 0 forces a ramp-down to 0 followed by shutdown.
- period_end  in  1  single-cycle pulse from the PWM counter on its wrap cycle.
- cmd_valid  in  1  host command valid.
- cmd_duty  in  DW  requested target duty count.
- cmd_ready  out  1  controller can accept a command.
- duty_out  out  DW  compare value driven into the PWM datapath.
- pwm_en  out  1  PWM core run enable.
- busy  out  1  high while ramping (state RAMP or STOP).
- clamp_err  out  1  last accepted command exceeded MAX_DUTY and was clamped.

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE, target=0.
  - duty_out=0, pwm_en=0, cmd_ready=1, busy=0, clamp_err=0.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - On accept: target <= min(cmd_duty, MAX_DUTY); clamp_err <= (cmd_duty > MAX_DUTY).
  - clamp_err is held until the next accepted command.
  - cmd_ready is decoded from state only: 1 in IDLE and HOLD, 0 in RAMP and STOP.
  - cmd_valid has no effect while cmd_ready=0; the host holds it.
- States:
  - IDLE: pwm_en=0, duty_out=0. Go to RAMP when enable=1 and target!=0; pwm_en is set on the transition. Commands are accepted here even when enable=0.
  - RAMP: on period_end, if |target-duty| <= STEP then duty <= target and go to HOLD. Otherwise duty moves STEP toward target.
  - RAMP arrival at zero: reaching duty=0 with target=0 goes to IDLE instead of HOLD, and pwm_en clears in the same update.
  - HOLD: duty is constant. If an accepted command gives target!=duty, go to RAMP; if target==duty, stay in HOLD.
  - STOP: entered from RAMP or HOLD when enable=0. On each period_end, duty decreases by min(STEP, duty). At duty=0 go to IDLE with pwm_en=0. target is retained.
- Priority:
  - In RAMP or HOLD, enable=0 overrides everything.
  - A command accepted in HOLD in the same cycle that enable falls still updates target, but the next state is STOP.
- Timing:
  - duty_out only changes on the cycle after a period_end pulse; latency is 1 clock.
  - A command accepted in the same cycle as period_end has no duty effect until the following period_end.
  - No change to duty_out is ever made without a period_end.
  - period_end in IDLE or HOLD is ignored.
- Arithmetic:
  - The difference target-duty is computed in DW+1 bits signed.
  - Each step saturates at target (or at 0 in STOP), so there is no wrap-around and no overshoot.
- Re-enable: enable rising while in STOP has no effect until IDLE is reached; the controller then re-ramps toward the retained target.
- Reset mid-ramp: outputs go to their reset values immediately. After reset, the controller waits in IDLE for a new command (target was cleared).

Decomposition:
- pwm_pkg holds:
  - the state encoding (IDLE, RAMP, HOLD, STOP, 2 bits);
  - the defaults PWM_DW=8, PWM_MAX_DUTY=100, PWM_STEP=5.
- One sub-module, pwm_step_calc: combinational next-duty computation (direction, saturation, done flag) from duty, target and STEP.
- The FSM, handshake and registers stay in pwm_ramp_controller.

Test Plan:
- Reset then soft-start: enable=1, command 50 -> accepted; pwm_en=1; duty_out 5,10,...,50 on 10 successive period_end pulses; then HOLD, busy=0, cmd_ready=1.
- Clamp: in HOLD at 50, command 200 -> clamp_err=1; ramp to 100 reached after 10 period_ends. Next command 30 -> clamp_err=0; ramp down 95,...,30.
- Non-multiple step: from 0, command 12 -> duty_out 5, 10, 12, then HOLD.
- Soft-stop: at HOLD 50, enable=0 -> cmd_ready=0, busy=1; duty 45,...,0 over 10 period_ends; then IDLE with pwm_en=0 on the same update as duty reaching 0.
- Simultaneous events: command 60 accepted in the same cycle as period_end while in HOLD at 50 -> duty_out stays 50 that period; becomes 55 after the next period_end.
- Async reset mid-ramp: assert rst between clock edges at duty 25 -> duty_out=0, pwm_en=0, cmd_ready=1 before the next edge. No change on period_end until a new command is accepted.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and default parameters for the PWM ramp controller
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      HOLD = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam int PWM_DW       = 8;
   localparam int PWM_MAX_DUTY = 100;
   localparam int PWM_STEP     = 5;

endpackage

// File: rtl/pwm_step_calc.sv
// rtl/pwm_step_calc.sv - one saturating ramp step of duty toward a target
import pwm_pkg::*;

module pwm_step_calc #(
   parameter int DW   = PWM_DW,
   parameter int STEP = PWM_STEP
) (
   input  logic [DW-1:0] duty,
   input  logic [DW-1:0] target,
   output logic [DW-1:0] next_duty,
   output logic          done
);

   localparam logic [DW:0]   STEP_W = STEP[DW:0];
   localparam logic [DW-1:0] STEP_D = STEP[DW-1:0];

   logic signed [DW:0] diff;
   logic        [DW:0] mag;

   // Signed DW+1 difference; within one STEP we land exactly on target, so no overshoot or wrap.
   always_comb begin
      diff = $signed({1'b0, target}) - $signed({1'b0, duty});
      mag  = diff[DW] ? -diff : diff;
      done = (mag <= STEP_W);
      if (done) begin
         next_duty = target;
      end else if (!diff[DW]) begin
         next_duty = duty + STEP_D;
      end else begin
         next_duty = duty - STEP_D;
      end
   end

endmodule

// File: rtl/pwm_ramp_controller.sv
// rtl/pwm_ramp_controller.sv - soft start/stop duty sequencer gating the PWM core
import pwm_pkg::*;

module pwm_ramp_controller #(
   parameter int DW       = PWM_DW,
   parameter int MAX_DUTY = PWM_MAX_DUTY,
   parameter int STEP     = PWM_STEP
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          period_end,
   input  logic          cmd_valid,
   input  logic [DW-1:0] cmd_duty,
   output logic          cmd_ready,
   output logic [DW-1:0] duty_out,
   output logic          pwm_en,
   output logic          busy,
   output logic          clamp_err
);

   localparam logic [DW-1:0] MAX_D = MAX_DUTY[DW-1:0];

   state_t        state, state_nxt;
   logic [DW-1:0] duty, duty_nxt;
   logic [DW-1:0] target, target_nxt;
   logic [DW-1:0] cmd_clamped;
   logic [DW-1:0] calc_target;
   logic [DW-1:0] calc_duty;
   logic          calc_done;
   logic          clamp_nxt;
   logic          accept;

   assign cmd_ready   = (state == IDLE) || (state == HOLD);
   assign busy        = (state == RAMP) || (state == STOP);
   assign pwm_en      = (state != IDLE);
   assign duty_out    = duty;
   assign accept      = cmd_valid & cmd_ready;
   assign cmd_clamped = (cmd_duty > MAX_D) ? MAX_D : cmd_duty;
   // Stopping ramps toward zero but keeps the host target for the next start.
   assign calc_target = (state == STOP) ? '0 : target;

   pwm_step_calc #(
      .DW   (DW),
      .STEP (STEP)
   ) u_step (
      .duty      (duty),
      .target    (calc_target),
      .next_duty (calc_duty),
      .done      (calc_done)
   );

   // State, duty, target and clamp flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         duty      <= '0;
         target    <= '0;
         clamp_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         duty      <= duty_nxt;
         target    <= target_nxt;
         clamp_err <= clamp_nxt;
      end
   end

   // Next state and duty; duty only moves on period_end so a period never sees a mid-cycle change.
   always_comb begin
      state_nxt  = state;
      duty_nxt   = duty;
      target_nxt = target;
      clamp_nxt  = clamp_err;
      if (accept) begin
         target_nxt = cmd_clamped;
         clamp_nxt  = (cmd_duty > MAX_D);
      end
      case (state)
         IDLE: begin
            if (enable && (target != '0)) state_nxt = RAMP;
         end
         RAMP: begin
            if (!enable) begin
               state_nxt = STOP;
            end else if (period_end) begin
               duty_nxt = calc_duty;
               if (calc_done) state_nxt = (calc_duty == '0) ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (!enable) begin
               state_nxt = STOP;
            end else if (accept && (cmd_clamped != duty)) begin
               state_nxt = RAMP;
            end
         end
         STOP: begin
            if (duty == '0) begin
               state_nxt = IDLE;
            end else if (period_end) begin
               duty_nxt = calc_duty;
               if (calc_duty == '0) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb/tb_pwm_ramp_controller.sv - directed self-checking bench for pwm_ramp_controller
module tb_pwm_ramp_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       period_end;
   logic       cmd_valid;
   logic [7:0] cmd_duty;
   logic       cmd_ready;
   logic [7:0] duty_out;
   logic       pwm_en;
   logic       busy;
   logic       clamp_err;

   int n_assert = 0;
   int n_fail   = 0;

   pwm_ramp_controller dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .period_end (period_end),
      .cmd_valid  (cmd_valid),
      .cmd_duty   (cmd_duty),
      .cmd_ready  (cmd_ready),
      .duty_out   (duty_out),
      .pwm_en     (pwm_en),
      .busy       (busy),
      .clamp_err  (clamp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_period();
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
   endtask

   task automatic send_cmd(input int v, input string tag);
      int accepted;
      accepted  = 0;
      cmd_valid = 1'b1;
      cmd_duty  = v[7:0];
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            tick();
            accepted = 1;
            break;
         end
         tick();
      end
      cmd_valid = 1'b0;
      chk(tag, accepted, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst        = 1'b1;
      enable     = 1'b0;
      period_end = 1'b0;
      cmd_valid  = 1'b0;
      cmd_duty   = '0;
      tick();
      tick();
      chk("rst_duty", duty_out, 0);
      chk("rst_pwm_en", pwm_en, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_clamp", clamp_err, 0);
      rst = 1'b0;
      tick();

      // Soft start to 50
      enable = 1'b1;
      tick();
      chk("idle_no_target_pwm_en", pwm_en, 0);
      send_cmd(50, "acc_50");
      tick();
      chk("start_pwm_en", pwm_en, 1);
      chk("start_busy", busy, 1);
      chk("start_cmd_ready", cmd_ready, 0);
      chk("start_duty", duty_out, 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("ramp_idle_cycle", duty_out, 5 * (i - 1));
         pulse_period();
         chk("ramp_up_50", duty_out, 5 * i);
      end
      chk("hold50_busy", busy, 0);
      chk("hold50_ready", cmd_ready, 1);
      pulse_period();
      chk("hold_ignores_period", duty_out, 50);

      // Clamp to 100, then down to 30
      send_cmd(200, "acc_200");
      chk("clamp_set", clamp_err, 1);
      chk("clamp_busy", busy, 1);
      for (int i = 1; i <= 10; i++) begin
         pulse_period();
         chk("ramp_up_100", duty_out, 50 + 5 * i);
      end
      chk("hold100_busy", busy, 0);
      send_cmd(30, "acc_30");
      chk("clamp_clear", clamp_err, 0);
      for (int i = 1; i <= 14; i++) begin
         pulse_period();
         chk("ramp_down_30", duty_out, 100 - 5 * i);
      end
      chk("hold30_busy", busy, 0);

      // Down to 0 via command, lands in IDLE
      send_cmd(0, "acc_0");
      for (int i = 1; i <= 6; i++) begin
         pulse_period();
         chk("ramp_down_0", duty_out, 30 - 5 * i);
      end
      chk("cmd0_pwm_en", pwm_en, 0);
      chk("cmd0_ready", cmd_ready, 1);

      // Non-multiple step: 5, 10, 12
      send_cmd(12, "acc_12");
      tick();
      chk("r12_busy", busy, 1);
      pulse_period();
      chk("r12_a", duty_out, 5);
      pulse_period();
      chk("r12_b", duty_out, 10);
      pulse_period();
      chk("r12_c", duty_out, 12);
      chk("r12_hold", busy, 0);

      // Back up to 50: 17,22,...,47,50
      send_cmd(50, "acc_50b");
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         pulse_period();
         cnt++;
         if (!busy) break;
      end
      chk("r50_pulses", cnt, 8);
      chk("r50_duty", duty_out, 50);

      // Soft stop
      enable = 1'b0;
      tick();
      chk("stop_ready", cmd_ready, 0);
      chk("stop_busy", busy, 1);
      chk("stop_duty_held", duty_out, 50);
      for (int i = 1; i <= 10; i++) begin
         pulse_period();
         chk("stop_down", duty_out, 50 - 5 * i);
         chk("stop_pwm_en", pwm_en, (i < 10) ? 1 : 0);
      end
      chk("stop_end_busy", busy, 0);
      chk("stop_end_ready", cmd_ready, 1);

      // Re-enable ramps toward retained target 50
      enable = 1'b1;
      tick();
      chk("reen_busy", busy, 1);
      for (int i = 1; i <= 10; i++) begin
         pulse_period();
         chk("reen_up", duty_out, 5 * i);
      end
      chk("reen_hold", busy, 0);

      // Command 60 with simultaneous period_end
      cmd_valid  = 1'b1;
      cmd_duty   = 8'd60;
      period_end = 1'b1;
      tick();
      cmd_valid  = 1'b0;
      period_end = 1'b0;
      chk("sim_duty_held", duty_out, 50);
      chk("sim_busy", busy, 1);
      tick();
      chk("sim_duty_held2", duty_out, 50);
      pulse_period();
      chk("sim_55", duty_out, 55);
      pulse_period();
      chk("sim_60", duty_out, 60);
      chk("sim_hold", busy, 0);

      // Ramp down toward 0, reset at 25
      send_cmd(0, "acc_0b");
      for (int i = 1; i <= 7; i++) begin
         pulse_period();
      end
      chk("pre_rst_duty", duty_out, 25);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_duty", duty_out, 0);
      chk("arst_pwm_en", pwm_en, 0);
      chk("arst_ready", cmd_ready, 1);
      chk("arst_busy", busy, 0);
      #1;
      rst = 1'b0;
      tick();
      pulse_period();
      pulse_period();
      chk("post_rst_duty", duty_out, 0);
      chk("post_rst_pwm_en", pwm_en, 0);
      send_cmd(10, "acc_10");
      tick();
      pulse_period();
      chk("post_rst_r1", duty_out, 5);
      pulse_period();
      chk("post_rst_r2", duty_out, 10);
      chk("post_rst_hold", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
